rsd_offset_gen: RTL and testbench
=================================

Name: rsd_offset_gen

Overview:
Decode-to-execute stage that sits directly downstream of the IFU store-destination offset decoder. It consumes the 5-bit one-hot offset select and the following bytecode operand bytes, and forms the local-variable store-destination (RSD) offset. The result is registered with stall and flush handling. It also tracks the `wide` (0xc4) prefix, so that a following store or iinc receives a 16-bit index instead of an 8-bit one.

Parameters:
OFF_W, 16, width of the registered RSD offset
CNT_W, 16, width of the optional store counter

Ports:
clk  input  1  core clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
dec_valid  input  1  decode slot holds a valid instruction this cycle
offset_sel_rsd  input  5  one-hot select: [0]=0, [1]=1, [2]=2, [3]=3, [4]=operand byte(s)
opc_byte1  input  8  first operand byte after the opcode
opc_byte2  input  8  second operand byte after the opcode
wide_seen  input  1  current opcode is the wide prefix 0xc4, already qualified by valid[0]
iu_hold  input  1  downstream stall; freezes this stage
iu_flush  input  1  pipeline flush; discards staged and pending state
dec_accept  output  1  stage takes the decode slot this cycle; equals dec_valid & !iu_hold & !iu_flush
rsd_vld  output  1  rsd_offset is valid
rsd_offset  output  OFF_W  registered store-destination offset
rsd_is_wide  output  1  rsd_offset came from a wide (16-bit) index
rsd_wide_err  output  1  one-cycle pulse: wide prefix followed by a non-operand store form
rsd_store_cnt  output  CNT_W  store counter, present only with the optional feature

Behaviour:
- Reset (sync, active-high) clears all outputs and the counter to 0; FSM enters NORM.
- Reset dominates flush; flush dominates hold; hold dominates capture.
- FSM states and transitions:
  - NORM: normal operation.
    - On accept with wide_seen=1: go to WIDE. Capture nothing; rsd_vld=0 next cycle.
  - WIDE: the next accepted instruction consumes the prefix, then the FSM returns to NORM.
- Capture on accept, 1-cycle latency. Outputs are registered; no combinational path from inputs to rsd_*.
- Select priority when offset_sel_rsd is not one-hot: [4] > [3] > [2] > [1] > [0]. An all-zero select is treated as [0].
- Offset in NORM:
  - sel[0] -> 0
  - sel[1..3] -> 1..3
  - sel[4] -> {8'h00, opc_byte1}
  - rsd_is_wide=0 in all cases.
- Offset in WIDE:
  - sel[4] -> {opc_byte1, opc_byte2}, rsd_is_wide=1.
  - Any other select -> offset per the NORM rule, rsd_is_wide=0, and rsd_wide_err pulses high for one cycle.
- A second wide_seen while in WIDE: stay in WIDE, no capture, rsd_wide_err pulses.
- Accept with wide_seen=0 sets rsd_vld=1 for the cycle after capture.
- No accept and no hold (bubble): rsd_vld=0 next cycle; rsd_offset and rsd_is_wide hold their last values.
- iu_hold=1: every register, including the FSM, holds. rsd_wide_err is forced low.
- iu_flush=1: next cycle rsd_vld=0, rsd_wide_err=0, FSM=NORM, and any pending wide prefix is dropped. The decode slot in the flush cycle is not accepted.
- Reset asserted mid-wide sequence: FSM returns to NORM; the prefix is lost.

Optional Feature:
- Macro: RSD_STORE_CNT_EN.
- Defined: rsd_store_cnt increments by 1 on each cycle that captures an offset whose select is not sel[0], i.e. any captured store/iinc. It saturates at all-ones, clears on reset, and holds during iu_hold.
- Undefined: no counter register is built and rsd_store_cnt is driven constant 0.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, dec_valid=0 -> all outputs 0, rsd_store_cnt=0, FSM in NORM.
- Short form: sel=5'b00100 with dec_valid, no hold -> next cycle rsd_vld=1, rsd_offset=16'h0002, rsd_is_wide=0.
- Operand form: sel=5'b10000, opc_byte1=8'hA5 -> next cycle rsd_offset=16'h00A5, rsd_is_wide=0.
- Wide sequence:
  - Stimulus: cycle N wide_seen=1; cycle N+1 sel=5'b10000, opc_byte1=8'h12, opc_byte2=8'h34.
  - Required: rsd_vld=0 at N+1; at N+2 rsd_vld=1, rsd_offset=16'h1234, rsd_is_wide=1.
- Wide error and flush:
  - Wide prefix, then sel=5'b00010 -> rsd_offset=16'h0001, rsd_wide_err=1 for one cycle.
  - Separately: wide prefix, then iu_flush=1, then sel=5'b10000 with opc_byte1=8'h07 -> rsd_offset=16'h0007, rsd_is_wide=0.
- Hold and counter (RSD_STORE_CNT_EN defined):
  - Capture sel=5'b01000 (offset 3), then iu_hold=1 for 3 cycles with new inputs.
  - Required: rsd_offset stays 3 and rsd_vld stays 1 during the hold; rsd_store_cnt=1.
  - Preloading the counter to 16'hFFFF and capturing a store leaves it at 16'hFFFF.

Source files
------------

// File: rtl/rsd_offset_gen.sv
// Store-destination (RSD) offset stage: registers the local-variable index for stores/iinc and tracks the wide prefix.
// Optional saturating store counter is built only when RSD_STORE_CNT_EN is defined.
module rsd_offset_gen #(
   parameter int OFF_W = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dec_valid,
   input  logic [4:0]       offset_sel_rsd,
   input  logic [7:0]       opc_byte1,
   input  logic [7:0]       opc_byte2,
   input  logic             wide_seen,
   input  logic             iu_hold,
   input  logic             iu_flush,
   output logic             dec_accept,
   output logic             rsd_vld,
   output logic [OFF_W-1:0] rsd_offset,
   output logic             rsd_is_wide,
   output logic             rsd_wide_err,
   output logic [CNT_W-1:0] rsd_store_cnt
);

   localparam logic [0:0] ST_NORM = 1'b0;
   localparam logic [0:0] ST_WIDE = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             rsd_vld_q, rsd_vld_d;
   logic [OFF_W-1:0] rsd_offset_q, rsd_offset_d;
   logic             rsd_is_wide_q, rsd_is_wide_d;
   logic             rsd_wide_err_q, rsd_wide_err_d;
   logic [15:0]      norm_val;
   logic             in_wide;

   assign dec_accept = dec_valid & ~iu_hold & ~iu_flush;
   assign in_wide    = (state_q == ST_WIDE);

   // Highest set select bit wins; an all-zero select falls through to offset 0.
   always_comb begin
      norm_val = 16'd0;
      if (offset_sel_rsd[4])      norm_val = {8'h00, opc_byte1};
      else if (offset_sel_rsd[3]) norm_val = 16'd3;
      else if (offset_sel_rsd[2]) norm_val = 16'd2;
      else if (offset_sel_rsd[1]) norm_val = 16'd1;
   end

   // Flush beats hold, hold beats capture; the error flag is a single-cycle pulse.
   always_comb begin
      state_d        = state_q;
      rsd_vld_d      = rsd_vld_q;
      rsd_offset_d   = rsd_offset_q;
      rsd_is_wide_d  = rsd_is_wide_q;
      rsd_wide_err_d = 1'b0;
      if (iu_flush) begin
         rsd_vld_d = 1'b0;
         state_d   = ST_NORM;
      end else if (iu_hold) begin
         state_d = state_q;
      end else if (!dec_valid) begin
         rsd_vld_d = 1'b0;
      end else if (wide_seen) begin
         rsd_vld_d      = 1'b0;
         state_d        = ST_WIDE;
         rsd_wide_err_d = in_wide;
      end else begin
         rsd_vld_d = 1'b1;
         state_d   = ST_NORM;
         if (in_wide && offset_sel_rsd[4]) begin
            rsd_offset_d  = OFF_W'({opc_byte1, opc_byte2});
            rsd_is_wide_d = 1'b1;
         end else begin
            rsd_offset_d   = OFF_W'(norm_val);
            rsd_is_wide_d  = 1'b0;
            rsd_wide_err_d = in_wide;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_NORM;
         rsd_vld_q      <= 1'b0;
         rsd_offset_q   <= '0;
         rsd_is_wide_q  <= 1'b0;
         rsd_wide_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         rsd_vld_q      <= rsd_vld_d;
         rsd_offset_q   <= rsd_offset_d;
         rsd_is_wide_q  <= rsd_is_wide_d;
         rsd_wide_err_q <= rsd_wide_err_d;
      end
   end

   assign rsd_vld      = rsd_vld_q;
   assign rsd_offset   = rsd_offset_q;
   assign rsd_is_wide  = rsd_is_wide_q;
   assign rsd_wide_err = rsd_wide_err_q;

`ifdef RSD_STORE_CNT_EN
   // Counts every captured store/iinc (any select other than the implicit 0 form).
   logic [CNT_W-1:0] store_cnt_q, store_cnt_d;
   logic             store_hit;

   assign store_hit = dec_accept & ~wide_seen & (|offset_sel_rsd[4:1]);

   always_comb begin
      store_cnt_d = store_cnt_q;
      if (store_hit && (store_cnt_q != {CNT_W{1'b1}}))
         store_cnt_d = store_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) store_cnt_q <= '0;
      else       store_cnt_q <= store_cnt_d;
   end

   assign rsd_store_cnt = store_cnt_q;
`else
   assign rsd_store_cnt = '0;
`endif

endmodule

// File: tb/tb_rsd_offset_gen.sv
// Self-checking bench for rsd_offset_gen: directed scenarios plus randomized traffic against a rule-level model.
// Uses a narrow counter so saturation is reachable quickly; counter checks expect 0 unless RSD_STORE_CNT_EN is defined.
module tb_rsd_offset_gen;

   localparam int OFF_W = 16;
   localparam int CNT_W = 4;
`ifdef RSD_STORE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             dec_valid;
   logic [4:0]       offset_sel_rsd;
   logic [7:0]       opc_byte1;
   logic [7:0]       opc_byte2;
   logic             wide_seen;
   logic             iu_hold;
   logic             iu_flush;
   logic             dec_accept;
   logic             rsd_vld;
   logic [OFF_W-1:0] rsd_offset;
   logic             rsd_is_wide;
   logic             rsd_wide_err;
   logic [CNT_W-1:0] rsd_store_cnt;

   int errors = 0;
   int checks = 0;

   // Reference state: what each output should be, plus whether a wide prefix is pending.
   logic        m_vld, m_wide, m_err, m_pend;
   logic [15:0] m_off;
   int          m_cnt;

   always #5 clk = ~clk;

   rsd_offset_gen #(.OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .dec_valid(dec_valid), .offset_sel_rsd(offset_sel_rsd),
      .opc_byte1(opc_byte1), .opc_byte2(opc_byte2), .wide_seen(wide_seen),
      .iu_hold(iu_hold), .iu_flush(iu_flush), .dec_accept(dec_accept),
      .rsd_vld(rsd_vld), .rsd_offset(rsd_offset), .rsd_is_wide(rsd_is_wide),
      .rsd_wide_err(rsd_wide_err), .rsd_store_cnt(rsd_store_cnt)
   );

   function automatic int sel_rank(input logic [4:0] s);
      for (int i = 4; i >= 1; i--) if (s[i]) return i;
      return 0;
   endfunction

   function automatic logic [CNT_W-1:0] exp_cnt();
      return CNT_EN ? CNT_W'(m_cnt) : '0;
   endfunction

   task automatic model_edge();
      int r;
      r = sel_rank(offset_sel_rsd);
      if (reset) begin
         m_vld = 0; m_off = 0; m_wide = 0; m_err = 0; m_pend = 0; m_cnt = 0;
      end else if (iu_flush) begin
         m_vld = 0; m_err = 0; m_pend = 0;
      end else if (iu_hold) begin
         m_err = 0;
      end else if (!dec_valid) begin
         m_vld = 0; m_err = 0;
      end else if (wide_seen) begin
         m_vld = 0; m_err = m_pend; m_pend = 1;
      end else begin
         m_vld  = 1;
         m_err  = m_pend && (r != 4);
         m_wide = m_pend && (r == 4);
         if (r == 4) m_off = m_pend ? {opc_byte1, opc_byte2} : {8'h00, opc_byte1};
         else        m_off = 16'(r);
         m_pend = 0;
         if (r != 0 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] s, input logic [7:0] b1, input logic [7:0] b2,
                        input logic ws, input logic h, input logic f);
      dec_valid = v; offset_sel_rsd = s; opc_byte1 = b1; opc_byte2 = b2;
      wide_seen = ws; iu_hold = h; iu_flush = f;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 5'b0, 8'h00, 8'h00, 0, 0, 0);
      step(); step();
      checks++;
      if (rsd_vld !== 1'b0 || rsd_offset !== 16'h0000 || rsd_is_wide !== 1'b0 ||
          rsd_wide_err !== 1'b0 || rsd_store_cnt !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got vld=%b off=%h wide=%b err=%b cnt=%0d, want all 0",
                  rsd_vld, rsd_offset, rsd_is_wide, rsd_wide_err, rsd_store_cnt);
      end
      reset = 1'b0;
   endtask

   task automatic test_short_form();
      drive(1, 5'b00100, 8'hFF, 8'hEE, 0, 0, 0);
      #1;
      checks++;
      if (dec_accept !== 1'b1) begin
         errors++; $display("[TB] FAIL short_accept: got %b want 1", dec_accept);
      end
      step();
      checks++;
      if (rsd_vld !== 1'b1 || rsd_offset !== 16'h0002 || rsd_is_wide !== 1'b0) begin
         errors++;
         $display("[TB] FAIL short_form: got vld=%b off=%h wide=%b want 1/0002/0", rsd_vld, rsd_offset, rsd_is_wide);
      end
      drive(0, 5'b0, 8'h00, 8'h00, 0, 0, 0);
      step();
      checks++;
      if (rsd_vld !== 1'b0 || rsd_offset !== 16'h0002) begin
         errors++; $display("[TB] FAIL bubble: got vld=%b off=%h want 0/0002", rsd_vld, rsd_offset);
      end
   endtask

   task automatic test_operand_form();
      drive(1, 5'b10000, 8'hA5, 8'h5A, 0, 0, 0);
      step();
      checks++;
      if (rsd_vld !== 1'b1 || rsd_offset !== 16'h00A5 || rsd_is_wide !== 1'b0) begin
         errors++;
         $display("[TB] FAIL operand_form: got vld=%b off=%h wide=%b want 1/00a5/0", rsd_vld, rsd_offset, rsd_is_wide);
      end
      drive(1, 5'b01011, 8'h00, 8'h00, 0, 0, 0);
      step();
      checks++;
      if (rsd_offset !== 16'h0003) begin
         errors++; $display("[TB] FAIL sel_priority: got off=%h want 0003", rsd_offset);
      end
   endtask

   task automatic test_wide_seq();
      drive(1, 5'b00001, 8'h00, 8'h00, 1, 0, 0);
      step();
      drive(1, 5'b10000, 8'h12, 8'h34, 0, 0, 0);
      checks++;
      if (rsd_vld !== 1'b0) begin
         errors++; $display("[TB] FAIL wide_prefix_vld: got %b want 0", rsd_vld);
      end
      step();
      checks++;
      if (rsd_vld !== 1'b1 || rsd_offset !== 16'h1234 || rsd_is_wide !== 1'b1 || rsd_wide_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wide_seq: got vld=%b off=%h wide=%b err=%b want 1/1234/1/0",
                  rsd_vld, rsd_offset, rsd_is_wide, rsd_wide_err);
      end
   endtask

   task automatic test_wide_err();
      drive(1, 5'b0, 8'h00, 8'h00, 1, 0, 0);
      step();
      drive(1, 5'b00010, 8'h77, 8'h88, 0, 0, 0);
      step();
      checks++;
      if (rsd_offset !== 16'h0001 || rsd_wide_err !== 1'b1 || rsd_is_wide !== 1'b0 || rsd_vld !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wide_err: got off=%h err=%b wide=%b vld=%b want 0001/1/0/1",
                  rsd_offset, rsd_wide_err, rsd_is_wide, rsd_vld);
      end
      drive(0, 5'b0, 8'h00, 8'h00, 0, 0, 0);
      step();
      checks++;
      if (rsd_wide_err !== 1'b0) begin
         errors++; $display("[TB] FAIL wide_err_pulse: got %b want 0", rsd_wide_err);
      end
      drive(1, 5'b0, 8'h00, 8'h00, 1, 0, 0);
      step(); step();
      checks++;
      if (rsd_wide_err !== 1'b1 || rsd_vld !== 1'b0) begin
         errors++; $display("[TB] FAIL double_wide: got err=%b vld=%b want 1/0", rsd_wide_err, rsd_vld);
      end
      drive(1, 5'b10000, 8'hAB, 8'hCD, 0, 0, 0);
      step();
      checks++;
      if (rsd_offset !== 16'hABCD || rsd_is_wide !== 1'b1) begin
         errors++; $display("[TB] FAIL double_wide_consume: got off=%h wide=%b want abcd/1", rsd_offset, rsd_is_wide);
      end
   endtask

   task automatic test_flush();
      drive(1, 5'b0, 8'h00, 8'h00, 1, 0, 0);
      step();
      drive(1, 5'b10000, 8'h55, 8'h66, 0, 0, 1);
      #1;
      checks++;
      if (dec_accept !== 1'b0) begin
         errors++; $display("[TB] FAIL flush_accept: got %b want 0", dec_accept);
      end
      step();
      checks++;
      if (rsd_vld !== 1'b0 || rsd_wide_err !== 1'b0) begin
         errors++; $display("[TB] FAIL flush_outputs: got vld=%b err=%b want 0/0", rsd_vld, rsd_wide_err);
      end
      drive(1, 5'b10000, 8'h07, 8'h99, 0, 0, 0);
      step();
      checks++;
      if (rsd_offset !== 16'h0007 || rsd_is_wide !== 1'b0 || rsd_wide_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_drops_prefix: got off=%h wide=%b err=%b want 0007/0/0", rsd_offset, rsd_is_wide, rsd_wide_err);
      end
   endtask

   task automatic test_hold();
      reset = 1'b1;
      drive(0, 5'b0, 8'h00, 8'h00, 0, 0, 0);
      step();
      reset = 1'b0;
      drive(1, 5'b01000, 8'h00, 8'h00, 0, 0, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1, 0);
         #1;
         checks++;
         if (dec_accept !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_accept: got %b want 0", dec_accept);
         end
         step();
         checks++;
         if (rsd_vld !== 1'b1 || rsd_offset !== 16'h0003 || rsd_wide_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_freeze: got vld=%b off=%h err=%b want 1/0003/0", rsd_vld, rsd_offset, rsd_wide_err);
         end
      end
      checks++;
      if (rsd_store_cnt !== (CNT_EN ? CNT_W'(1) : '0)) begin
         errors++; $display("[TB] FAIL hold_cnt: got %0d want %0d", rsd_store_cnt, CNT_EN ? 1 : 0);
      end
      drive(0, 5'b0, 8'h00, 8'h00, 0, 0, 0);
      step();
   endtask

   task automatic test_counter_sat();
      for (int i = 0; i < 20; i++) begin
         drive(1, 5'b00010, 8'h00, 8'h00, 0, 0, 0);
         step();
      end
      checks++;
      if (rsd_store_cnt !== (CNT_EN ? {CNT_W{1'b1}} : '0)) begin
         errors++; $display("[TB] FAIL cnt_saturate: got %0d want %0d", rsd_store_cnt, CNT_EN ? (1 << CNT_W) - 1 : 0);
      end
   endtask

   task automatic test_random();
      logic exp_acc;
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0));
         #1;
         exp_acc = dec_valid & ~iu_hold & ~iu_flush;
         checks++;
         if (dec_accept !== exp_acc) begin
            errors++; $display("[TB] FAIL rand_accept[%0d]: got %b want %b", i, dec_accept, exp_acc);
         end
         step();
         checks++;
         if (rsd_vld !== m_vld || rsd_offset !== m_off || rsd_is_wide !== m_wide ||
             rsd_wide_err !== m_err || rsd_store_cnt !== exp_cnt()) begin
            errors++;
            $display("[TB] FAIL rand_outputs[%0d]: got vld=%b off=%h wide=%b err=%b cnt=%0d want %b/%h/%b/%b/%0d",
                     i, rsd_vld, rsd_offset, rsd_is_wide, rsd_wide_err, rsd_store_cnt,
                     m_vld, m_off, m_wide, m_err, exp_cnt());
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 5'b0, 8'h00, 8'h00, 0, 0, 0);
      test_reset();
      test_short_form();
      test_operand_form();
      test_wide_seq();
      test_wide_err();
      test_flush();
      test_hold();
      test_counter_sat();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
